// File: rtl/mips_soc_pkg.sv
// Shared definitions for the MIPS SoC data-side responder.
//   - Region codes carried in addr[31:28].
//   - Byte offsets of the memory-mapped registers.
//   - Bit positions inside the timer control register.
//   - Helpers that decode the region and match a word offset.
package mips_soc_pkg;

  localparam logic [3:0] RAM_REGION  = 4'h0;
  localparam logic [3:0] MMIO_REGION = 4'h1;

  localparam logic [7:0] GPIO_OUT_OFF = 8'h00;
  localparam logic [7:0] GPIO_IN_OFF  = 8'h04;
  localparam logic [7:0] TCNT_OFF     = 8'h08;
  localparam logic [7:0] TCMP_OFF     = 8'h0C;
  localparam logic [7:0] TCTRL_OFF    = 8'h10;
  localparam logic [7:0] TSTAT_OFF    = 8'h14;

  localparam int TCTRL_EN_BIT       = 0;
  localparam int TCTRL_IRQ_EN_BIT   = 1;
  localparam int TCTRL_AUTO_CLR_BIT = 2;
  localparam int TCTRL_W            = 3;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } regionT;

  function automatic regionT decodeRegion(input logic [3:0] topNibble);
    regionT r;
    case (topNibble)
      RAM_REGION:  r = REGION_RAM;
      MMIO_REGION: r = REGION_MMIO;
      default:     r = REGION_NONE;
    endcase
    return r;
  endfunction

  // Accesses are word-only, so registers are matched on the word offset
  // (byte offset bits [7:2]); byte-lane bits never select a different register.
  function automatic logic wordOffsetIs(input logic [5:0] wordOff, input logic [7:0] regOff);
    return wordOff == regOff[7:2];
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Prescaled compare timer with a sticky match flag and a level interrupt.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   wrEn            register write strobe (already qualified by MMIO decode)
//   wordOff         word offset of the access (byte offset bits [7:2])
//   wrData          store data
//   tcntVal         current counter value
//   tcmpVal         compare value
//   tctrlVal        control register, zero-extended
//   tstatVal        status register (bit0 = match flag), zero-extended
//   irq             flag & irq_en
module mmio_timer
  import mips_soc_pkg::*;
#(
  parameter int PRESC_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic [5:0]  wordOff,
  input  logic [31:0] wrData,
  output logic [31:0] tcntVal,
  output logic [31:0] tcmpVal,
  output logic [31:0] tctrlVal,
  output logic [31:0] tstatVal,
  output logic        irq
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0]      prescReg, prescNext;
  logic [31:0]        tcntReg, tcntNext;
  logic [31:0]        tcmpReg, tcmpNext;
  logic [TCTRL_W-1:0] tctrlReg, tctrlNext;
  logic               flagReg, flagNext;

  logic enable, tick, match;
  logic wrTcnt, wrTcmp, wrTctrl, wrTstat;

  assign enable = tctrlReg[TCTRL_EN_BIT];
  // With PRESC_DIV=1 the prescaler is stuck at 0 == PRESC_LAST, so every
  // enabled clock ticks.
  assign tick   = enable && (prescReg == PRESC_LAST);
  assign match  = tick && (tcntReg == tcmpReg);

  assign wrTcnt  = wrEn && wordOffsetIs(wordOff, TCNT_OFF);
  assign wrTcmp  = wrEn && wordOffsetIs(wordOff, TCMP_OFF);
  assign wrTctrl = wrEn && wordOffsetIs(wordOff, TCTRL_OFF);
  assign wrTstat = wrEn && wordOffsetIs(wordOff, TSTAT_OFF);

  always_comb begin
    prescNext = prescReg;
    tcntNext  = tcntReg;
    tcmpNext  = tcmpReg;
    tctrlNext = tctrlReg;
    flagNext  = flagReg;

    // Decisions use the current enable, so a write that clears enable in a
    // tick cycle still lets that tick land; the prescaler then returns to 0.
    if (!enable || tick) begin
      prescNext = '0;
    end else begin
      prescNext = prescReg + PW'(1);
    end

    // A CPU load of the counter overrides the tick's increment, but the
    // match evaluated on the old value is still recorded below.
    if (wrTcnt) begin
      tcntNext = wrData;
    end else if (tick) begin
      tcntNext = (match && tctrlReg[TCTRL_AUTO_CLR_BIT]) ? 32'd0 : tcntReg + 32'd1;
    end

    if (wrTcmp) begin
      tcmpNext = wrData;
    end

    if (wrTctrl) begin
      tctrlNext = wrData[TCTRL_W-1:0];
    end

    // A new match beats a simultaneous write-1-to-clear.
    if (match) begin
      flagNext = 1'b1;
    end else if (wrTstat && wrData[0]) begin
      flagNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescReg <= '0;
      tcntReg  <= '0;
      tcmpReg  <= 32'hFFFF_FFFF;
      tctrlReg <= '0;
      flagReg  <= 1'b0;
    end else begin
      prescReg <= prescNext;
      tcntReg  <= tcntNext;
      tcmpReg  <= tcmpNext;
      tctrlReg <= tctrlNext;
      flagReg  <= flagNext;
    end
  end

  assign tcntVal  = tcntReg;
  assign tcmpVal  = tcmpReg;
  assign tctrlVal = 32'(tctrlReg);
  assign tstatVal = 32'(flagReg);
  assign irq      = flagReg & tctrlReg[TCTRL_IRQ_EN_BIT];

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder for the pipelined MIPS core. Answers the
// memory-stage port from an on-chip data RAM and a small MMIO region
// (GPIO plus the compare timer).
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   memwrite      write strobe from the memory stage
//   addr          byte address (word accesses only; addr[1:0] ignored)
//   writedata     store data
//   readdata      load data, combinational from the current addr
//   gpio_in       asynchronous external inputs
//   gpio_out      registered GPIO outputs
//   irq           timer interrupt, level-sensitive
module dmem_responder
  import mips_soc_pkg::*;
#(
  parameter int AW        = 10,
  parameter int GPIO_W    = 16,
  parameter int PRESC_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  regionT      region;
  logic [AW-1:0] ramIdx;
  logic [5:0]  wordOff;
  logic        ramWr, mmioWr;

  assign region  = decodeRegion(addr[31:28]);
  // Address bits above the RAM index inside the RAM region simply alias.
  assign ramIdx  = addr[AW+1:2];
  assign wordOff = addr[7:2];
  assign ramWr   = memwrite && (region == REGION_RAM);
  assign mmioWr  = memwrite && (region == REGION_MMIO);

  // Data RAM: read is asynchronous so loads complete in the same cycle and
  // a read concurrent with a write to the same word sees the old contents.
  logic [31:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (ramWr) begin
      ram[ramIdx] <= writedata;
    end
  end

  // GPIO output register and 2-flop input synchronizer.
  logic [GPIO_W-1:0] gpioOutReg;
  logic [GPIO_W-1:0] gpioSync1Reg, gpioSync2Reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpioOutReg   <= '0;
      gpioSync1Reg <= '0;
      gpioSync2Reg <= '0;
    end else begin
      gpioSync1Reg <= gpio_in;
      gpioSync2Reg <= gpioSync1Reg;
      if (mmioWr && wordOffsetIs(wordOff, GPIO_OUT_OFF)) begin
        gpioOutReg <= writedata[GPIO_W-1:0];
      end
    end
  end

  assign gpio_out = gpioOutReg;

  logic [31:0] tcntVal, tcmpVal, tctrlVal, tstatVal;

  mmio_timer #(
    .PRESC_DIV (PRESC_DIV)
  ) timer (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (mmioWr),
    .wordOff  (wordOff),
    .wrData   (writedata),
    .tcntVal  (tcntVal),
    .tcmpVal  (tcmpVal),
    .tctrlVal (tctrlVal),
    .tstatVal (tstatVal),
    .irq      (irq)
  );

  always_comb begin
    readdata = '0;
    case (region)
      REGION_RAM: readdata = ram[ramIdx];
      REGION_MMIO: begin
        case (wordOff)
          GPIO_OUT_OFF[7:2]: readdata = 32'(gpioOutReg);
          GPIO_IN_OFF[7:2]:  readdata = 32'(gpioSync2Reg);
          TCNT_OFF[7:2]:     readdata = tcntVal;
          TCMP_OFF[7:2]:     readdata = tcmpVal;
          TCTRL_OFF[7:2]:    readdata = tctrlVal;
          TSTAT_OFF[7:2]:    readdata = tstatVal;
          default:           readdata = '0;
        endcase
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations, a randomized phase, and a behavioural reference model that
// a compare process checks against on every falling clock edge.
module tb_dmem_responder;

  localparam int AW        = 10;
  localparam int GPIO_W    = 16;
  localparam int PRESC_DIV = 4;

  localparam logic [31:0] A_GPIO_OUT = 32'h1000_0000;
  localparam logic [31:0] A_GPIO_IN  = 32'h1000_0004;
  localparam logic [31:0] A_TCNT     = 32'h1000_0008;
  localparam logic [31:0] A_TCMP     = 32'h1000_000C;
  localparam logic [31:0] A_TCTRL    = 32'h1000_0010;
  localparam logic [31:0] A_TSTAT    = 32'h1000_0014;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              memwrite = 1'b0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       writedata = 32'h0;
  logic [31:0]       readdata;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              irq;

  always #5 clk = ~clk;

  dmem_responder #(
    .AW        (AW),
    .GPIO_W    (GPIO_W),
    .PRESC_DIV (PRESC_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]       mRam   [1<<AW];
  bit                mValid [1<<AW];
  logic [GPIO_W-1:0] mGpioOut, mSync1, mSync2;
  logic [31:0]       mCnt, mCmp;
  logic [2:0]        mCtrl;
  bit                mFlag;
  int                mPresc;

  always @(posedge clk or negedge rst) begin : modelUpdate
    bit tick, hit;
    int idx;
    if (!rst) begin
      mGpioOut = '0; mSync1 = '0; mSync2 = '0;
      mCnt = 0; mCmp = 32'hFFFF_FFFF; mCtrl = 0; mFlag = 0; mPresc = 0;
    end else begin
      tick = mCtrl[0] && (mPresc == PRESC_DIV - 1);
      hit  = tick && (mCnt == mCmp);
      mPresc = (mCtrl[0] && !tick) ? mPresc + 1 : 0;
      if (tick) mCnt = (hit && mCtrl[2]) ? 32'd0 : mCnt + 32'd1;
      if (hit) mFlag = 1;
      mSync2 = mSync1;
      mSync1 = gpio_in;
      if (memwrite) begin
        if (addr[31:28] == 4'h0) begin
          idx = int'(addr[AW+1:2]);
          mRam[idx] = writedata;
          mValid[idx] = 1;
        end else if (addr[31:28] == 4'h1) begin
          case (addr[7:2])
            6'd0: mGpioOut = writedata[GPIO_W-1:0];
            6'd2: mCnt = writedata;
            6'd3: mCmp = writedata;
            6'd4: mCtrl = writedata[2:0];
            6'd5: if (writedata[0] && !hit) mFlag = 0;
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] r = 32'h0;
    if (a[31:28] == 4'h0) r = mRam[int'(a[AW+1:2])];
    else if (a[31:28] == 4'h1) begin
      case (a[7:2])
        6'd0: r = 32'(mGpioOut);
        6'd1: r = 32'(mSync2);
        6'd2: r = mCnt;
        6'd3: r = mCmp;
        6'd4: r = 32'(mCtrl);
        6'd5: r = 32'(mFlag);
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  function automatic bit modelKnown(input logic [31:0] a);
    if (a[31:28] == 4'h0) return mValid[int'(a[AW+1:2])];
    return 1;
  endfunction

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (checkEn && rst) begin
      if (modelKnown(addr)) check("cycle_readdata", readdata, modelRead(addr));
      check("cycle_gpio_out", 32'(gpio_out), 32'(mGpioOut));
      check("cycle_irq", 32'(irq), 32'(mFlag & mCtrl[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; addr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
    $display("wr  addr=%h data=%h", a, d);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; addr = a;
    #2;
    check(name, readdata, exp);
    $display("rd  addr=%h data=%h", a, readdata);
  endtask

  task automatic idle(input int n);
    memwrite = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIrq(input int bound, output int n);
    n = 0;
    while (!irq && n < bound) begin @(posedge clk); #1; n++; end
  endtask

  initial begin
    int n;
    logic [31:0] a;
    int sel;

    #1 rst = 1'b0;
    addr = A_TCMP;
    #3;
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tcmp", readdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    checkEn = 1'b1;
    rd("rst_tcnt", A_TCNT, 32'h0);
    rd("rst_tctrl", A_TCTRL, 32'h0);

    // RAM access, low-bit ignore, aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_read", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
    check("model_ram", modelRead(32'h0000_0010), 32'hDEAD_BEEF);

    // Unmapped region and GPIO output
    rd("unmapped_rd", 32'h2000_0000, 32'h0);
    wr(32'h2000_0000, 32'h5555_5555);
    rd("unmapped_after_wr", 32'h2000_0000, 32'h0);
    rd("ram_untouched", 32'h0000_0010, 32'hDEAD_BEEF);
    wr(A_GPIO_OUT, 32'h1234_ABCD);
    check("gpio_out_val", 32'(gpio_out), 32'h0000_ABCD);
    rd("gpio_out_rd", A_GPIO_OUT, 32'h0000_ABCD);

    // GPIO input synchronizer latency
    addr = A_GPIO_IN;
    gpio_in = 16'h00A5;
    @(posedge clk); #1;
    check("gpio_in_1clk", readdata, 32'h0);
    @(posedge clk); #1;
    check("gpio_in_2clk", readdata, 32'h0000_00A5);

    // Timer match, auto-clear, irq latency, W1C
    wr(A_TCMP, 32'd3);
    wr(A_TCNT, 32'd0);
    wr(A_TCTRL, 32'h7);
    waitIrq(40, n);
    check("irq_latency", 32'(n), 32'd16);
    rd("tcnt_autoclr", A_TCNT, 32'h0);
    rd("tstat_set", A_TSTAT, 32'h1);
    check("model_flag", 32'(mFlag), 32'h1);
    wr(A_TSTAT, 32'h1);
    check("irq_w1c", 32'(irq), 32'h0);

    // Counter load on a tick cycle
    wr(A_TCTRL, 32'h0);
    idle(1);
    wr(A_TCNT, 32'd50);
    wr(A_TCTRL, 32'h1);
    idle(3);
    wr(A_TCNT, 32'd100);
    rd("tcnt_write_wins", A_TCNT, 32'd100);
    // Load on a tick whose old value matched: flag still set
    wr(A_TCMP, 32'd100);
    idle(2);
    wr(A_TCNT, 32'd7);
    rd("tcnt_after_load", A_TCNT, 32'd7);
    rd("flag_on_load_match", A_TSTAT, 32'h1);
    check("irq_masked", 32'(irq), 32'h0);
    // W1C colliding with a new match
    wr(A_TCMP, 32'd8);
    idle(3);
    wr(A_TSTAT, 32'h1);
    rd("tstat_cleared", A_TSTAT, 32'h0);
    idle(2);
    wr(A_TSTAT, 32'h1);
    rd("set_beats_w1c", A_TSTAT, 32'h1);
    rd("tcnt_no_autoclr", A_TCNT, 32'd9);
    // 32-bit wrap
    wr(A_TCMP, 32'd5);
    wr(A_TCNT, 32'hFFFF_FFFF);
    idle(2);
    rd("tcnt_wrap", A_TCNT, 32'h0);
    wr(A_TCTRL, 32'h0);

    // Randomized phase, checked by the compare process
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      if (sel < 4) begin
        a[31:28] = 4'h0;
        a[AW+1:2] = AW'($urandom_range(0, 63));
      end else if (sel < 8) begin
        a[31:28] = 4'h1;
        a[7:0] = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      end else begin
        a[31:28] = 4'($urandom_range(2, 15));
      end
      addr = a;
      memwrite = ($urandom_range(0, 2) == 0);
      writedata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if ($urandom_range(0, 9) == 0) gpio_in = GPIO_W'($urandom);
      $display("rnd %s addr=%h data=%h", memwrite ? "wr" : "rd", addr, writedata);
      @(posedge clk); #1;
    end
    memwrite = 1'b0;

    // Asynchronous reset while counting
    wr(A_TCTRL, 32'h0);
    wr(A_GPIO_OUT, 32'hFFFF_5A5A);
    wr(A_TCMP, 32'd0);
    wr(A_TCNT, 32'd0);
    wr(A_TCTRL, 32'h3);
    waitIrq(20, n);
    check("irq_before_reset", 32'(irq), 32'h1);
    rd("tcnt_before_reset", A_TCNT, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tcnt", readdata, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_gpio", 32'(gpio_out), 32'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rd("tcmp_after_reset", A_TCMP, 32'hFFFF_FFFF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined MIPS core: it answers the core's memory-stage port (write strobe, word address, write data, read data) from an on-chip data RAM and a small memory-mapped peripheral region. It contains a GPIO block and a prescaled compare timer with an interrupt output. It sits beside the core in the SoC top and is the far end of the core's data interface.

## Interface
- `AW`, 10: data RAM word-address bits; capacity is 2^AW words.
- `GPIO_W`, 16: GPIO output and input width.
- `PRESC_DIV`, 4: timer tick period in clocks; minimum 1.
- `clk`  in  1  system clock; every register is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  write strobe from the memory stage.
- `addr`  in  32  byte address, which is the memory-stage ALU result.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data.
- `gpio_in`  in  GPIO_W  asynchronous external inputs.
- `gpio_out`  out  GPIO_W  registered outputs.
- `irq`  out  1  timer interrupt, level-sensitive.

## Operation
- Accesses are word-only. `addr[1:0]` is ignored.
- Address decode:
  - **RAM:** `addr[31:28]==4'h0`. RAM index is `addr[AW+1:2]`. Upper bits inside the region alias.
  - **MMIO:** `addr[31:28]==4'h1`. Register offset is `addr[7:0]`.
  - **Other:** reads return 0, writes are ignored.
- MMIO registers (offset, access, meaning):
  - `0x00` GPIO_OUT, RW, low `GPIO_W` bits.
  - `0x04` GPIO_IN, RO, the 2-flop synchronized `gpio_in`.
  - `0x08` TCNT, RW. A write loads the counter.
  - `0x0C` TCMP, RW, compare value.
  - `0x10` TCTRL, RW: bit0 = enable, bit1 = irq_en, bit2 = auto_clear.
  - `0x14` TSTAT: bit0 = match flag. Writing 1 to bit0 clears it.
  - All other offsets read 0.
  - Unused upper bits read 0.
- Reads have no side effects. `readdata` is a combinational mux of the RAM word or the MMIO register selected by the current `addr`.
- Timer operation:
  - The prescaler counts 0..PRESC_DIV-1 while enable=1. A tick occurs when the prescaler is at PRESC_DIV-1; the prescaler then wraps to 0.
  - The prescaler holds at 0 while enable=0.
  - On a tick with TCNT==TCMP: set the match flag, and load TCNT with 0 if auto_clear=1, otherwise TCNT+1.
  - On a tick with TCNT!=TCMP: TCNT+1, modulo 2^32 (wraps to 0 after 0xFFFFFFFF).
- `irq = flag & irq_en`.

## Timing
- RAM and register writes take effect at the rising edge where `memwrite`=1. A read of the same location in the next cycle returns the new value.
- A read in the same cycle as a write to that location returns the old value.
- Load latency is 0 cycles (combinational), so the core never stalls.
- `gpio_in` reaches GPIO_IN 2 clocks after it becomes stable.
- `irq` is registered-flag based: it rises 1 clock after the matching tick edge.
- Reset values:
  - `gpio_out`=0, TCNT=0, TCMP=0xFFFFFFFF, TCTRL=0, flag=0, prescaler=0, synchronizer flops=0.
  - Therefore `irq`=0. `readdata` follows the decode.
  - RAM contents are not reset.
- Reset asserted mid-count clears all timer state immediately, without waiting for a clock edge.
- Simultaneous events:
  - A CPU write to TCNT in the same cycle as a tick: the write wins and no increment occurs. If the old TCNT matched TCMP, the match is still flagged.
  - W1C clear of the flag in the same cycle as a new match: the set wins.
  - A write to TCTRL that clears enable in a tick cycle: the tick still applies and the prescaler goes to 0.
- PRESC_DIV=1 means a tick every enabled clock.

## Structure
- Shared package `mips_soc_pkg`:
  - Region constants `RAM_REGION=4'h0` and `MMIO_REGION=4'h1`.
  - MMIO offset constants `GPIO_OUT_OFF`, `GPIO_IN_OFF`, `TCNT_OFF`, `TCMP_OFF`, `TCTRL_OFF`, `TSTAT_OFF`.
  - TCTRL bit indices.
- One sub-module, `mmio_timer`, containing the prescaler, TCNT, TCMP, TCTRL and the flag. Its inputs are the write strobe, offset and data. Its outputs are the register read values and `irq`.
- The RAM, decode, GPIO and synchronizer stay in `dmem_responder`.

## Test plan
- **RAM access:** write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0013 → 0xDEADBEEF (low address bits ignored). With AW=10, read 0x0000_1010 → 0xDEADBEEF (alias).
- **Unmapped and GPIO:** read 0x2000_0000 → 0, and a write to it changes nothing. Write 0x1000_0000 ← 0x1234ABCD → `gpio_out`=0xABCD.
- **GPIO input sync:** set `gpio_in`=0x00A5 → GPIO_IN reads 0 for the first clock and 0x00A5 from the 2nd clock on.
- **Timer match and W1C:** PRESC_DIV=4, TCMP=3, TCTRL=0b111 → `irq` rises 1 clock after the tick on which TCNT==3, and TCNT returns to 0. Write TSTAT ← 1 → `irq` falls next clock.
- **Timer collisions:**
  - Write TCNT ← 100 on a tick cycle → TCNT=100, not 101.
  - W1C in the same cycle as a new match → flag stays 1.
  - With auto_clear=0, TCNT=0xFFFFFFFF plus one tick → TCNT=0.
- **Mid-count reset:** assert `rst`=0 asynchronously while counting → TCNT=0, `irq`=0, `gpio_out`=0 before the next clock edge. TCMP reads 0xFFFFFFFF after release.
